// File: rtl/sram_chunk_writer_if.sv
`default_nettype none
// ============================================================================
// sram_chunk_writer_if : dense beat input and compressed SRAM write port
// Rev 1.0
// ============================================================================
interface sram_chunk_writer_if #(
  parameter int BUS_SIZE       = 32,
  parameter int WR_DAT_CYC_NUM = 4,
  parameter int CHUNK_NUM      = 16
);
  logic [BUS_SIZE*8-1:0]               dense_dat;
  logic                                dense_valid;
  logic                                dense_ready;
  logic [BUS_SIZE-1:0]                 wr_sparsemap;
  logic [BUS_SIZE*8-1:0]               wr_nonzero_data;
  logic                                wr_valid;
  logic [$clog2(WR_DAT_CYC_NUM)-1:0]   wr_dat_count;
  logic [$clog2(CHUNK_NUM)-1:0]        wr_chunk_count;
  logic [$clog2(BUS_SIZE+1)-1:0]       wr_nz_count;

  // The writer owns the write port and the ready; the environment owns the beats.
  modport master (
    input  dense_dat, dense_valid,
    output dense_ready, wr_sparsemap, wr_nonzero_data, wr_valid,
           wr_dat_count, wr_chunk_count, wr_nz_count
  );

  modport slave (
    output dense_dat, dense_valid,
    input  dense_ready, wr_sparsemap, wr_nonzero_data, wr_valid,
           wr_dat_count, wr_chunk_count, wr_nz_count
  );
endinterface
`default_nettype wire

// File: rtl/sram_chunk_writer.sv
`default_nettype none
// ============================================================================
// sram_chunk_writer : compresses dense beats into sparsemap + packed nonzeros
// Rev 1.0
// ============================================================================
module sram_chunk_writer #(
  parameter int BUS_SIZE       = 32,
  parameter int WR_DAT_CYC_NUM = 4,
  parameter int CHUNK_NUM      = 16
) (
  input  wire logic                           clk_i,
  input  wire logic                           rst_i,
  input  wire logic                           start_i,
  input  wire logic [$clog2(CHUNK_NUM)-1:0]   chunk_base_i,
  input  wire logic [$clog2(CHUNK_NUM):0]     chunk_len_i,
  output logic                                busy_o,
  output logic                                done_o,
  sram_chunk_writer_if.master                 bus
);
  localparam int BW  = $clog2(WR_DAT_CYC_NUM);
  localparam int CW  = $clog2(CHUNK_NUM);
  localparam int LW  = CW + 1;
  localparam int NZW = $clog2(BUS_SIZE + 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(WR_DAT_CYC_NUM - 1);
  localparam logic [CW-1:0] SLOT_LAST = CW'(CHUNK_NUM - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   slot_q, slot_d;
  logic [LW-1:0]   len_q, len_d;
  logic [LW-1:0]   chunk_q, chunk_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic            accept;
  logic            last_beat;

  logic [BUS_SIZE-1:0]   cmp_map;
  logic [BUS_SIZE*8-1:0] cmp_data;
  logic [NZW-1:0]        cmp_nz;

  logic [BUS_SIZE-1:0]   map_q;
  logic [BUS_SIZE*8-1:0] data_q;
  logic [NZW-1:0]        nz_q;
  logic                  wr_valid_q;
  logic [BW-1:0]         wr_dat_q;
  logic [CW-1:0]         wr_slot_q;

  // slot_q tracks (base + chunk_idx) mod CHUNK_NUM incrementally.
  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    len_d     = len_q;
    chunk_d   = chunk_q;
    beat_d    = beat_q;
    accept    = (state_q == ST_RUN) && bus.dense_valid;
    last_beat = (beat_q == BEAT_LAST) && (chunk_q == len_q - LW'(1));
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          slot_d  = chunk_base_i;
          len_d   = chunk_len_i;
          chunk_d = '0;
          beat_d  = '0;
          state_d = (chunk_len_i == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept) begin
          if (beat_q == BEAT_LAST) begin
            beat_d  = '0;
            chunk_d = chunk_q + LW'(1);
            slot_d  = (slot_q == SLOT_LAST) ? '0 : slot_q + CW'(1);
          end else begin
            beat_d = beat_q + BW'(1);
          end
          if (last_beat) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Walking from the top byte down and shifting in each nonzero byte leaves
  // the lowest-index nonzero byte at position 0.
  always_comb begin
    cmp_map  = '0;
    cmp_data = '0;
    cmp_nz   = '0;
    for (int k = BUS_SIZE - 1; k >= 0; k--) begin
      if (bus.dense_dat[8*k +: 8] != 8'h00) begin
        cmp_map[k] = 1'b1;
        cmp_data   = {cmp_data[BUS_SIZE*8-9:0], bus.dense_dat[8*k +: 8]};
        cmp_nz     = cmp_nz + NZW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      slot_q     <= '0;
      len_q      <= '0;
      chunk_q    <= '0;
      beat_q     <= '0;
      map_q      <= '0;
      data_q     <= '0;
      nz_q       <= '0;
      wr_valid_q <= 1'b0;
      wr_dat_q   <= '0;
      wr_slot_q  <= '0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      len_q      <= len_d;
      chunk_q    <= chunk_d;
      beat_q     <= beat_d;
      wr_valid_q <= accept;
      if (accept) begin
        map_q     <= cmp_map;
        data_q    <= cmp_data;
        nz_q      <= cmp_nz;
        wr_dat_q  <= beat_q;
        wr_slot_q <= slot_q;
      end
    end
  end

  assign bus.dense_ready     = (state_q == ST_RUN);
  assign bus.wr_sparsemap    = map_q;
  assign bus.wr_nonzero_data = data_q;
  assign bus.wr_nz_count     = nz_q;
  assign bus.wr_valid        = wr_valid_q;
  assign bus.wr_dat_count    = wr_dat_q;
  assign bus.wr_chunk_count  = wr_slot_q;
  assign busy_o              = (state_q != ST_IDLE);
  assign done_o              = (state_q == ST_DONE);
endmodule
`default_nettype wire

// File: tb/tb_sram_chunk_writer.sv
`default_nettype none
// ============================================================================
// tb_sram_chunk_writer : scoreboard bench for sram_chunk_writer
// Rev 1.0
// ============================================================================
module tb_sram_chunk_writer;
  localparam int BUS = 32;
  localparam int W   = 4;
  localparam int CN  = 16;
  localparam int CW  = $clog2(CN);
  localparam int LW  = CW + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] base = '0;
  logic [LW-1:0] len = '0;
  logic          busy, done;

  sram_chunk_writer_if #(.BUS_SIZE(BUS), .WR_DAT_CYC_NUM(W), .CHUNK_NUM(CN)) bus ();

  sram_chunk_writer #(.BUS_SIZE(BUS), .WR_DAT_CYC_NUM(W), .CHUNK_NUM(CN)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .chunk_base_i (base),
    .chunk_len_i  (len),
    .busy_o       (busy),
    .done_o       (done),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BUS-1:0]   sm;
    logic [BUS*8-1:0] data;
    int               nz;
    int               dat;
    int               chunk;
    bit               last;
  } exp_t;

  exp_t q[$];
  int vectors = 0, errors = 0;
  int done_seen = 0, done_exp = 0, busy_cycles = 0;
  int cur_base = 0, cur_len = 0, cur_i = 0;

  task automatic check(input string name, input logic [BUS*8-1:0] act, input logic [BUS*8-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: collect nonzero bytes in order, then lay them out from byte 0.
  function automatic exp_t model(input logic [BUS*8-1:0] beat, input int i, input int b, input int l);
    logic [7:0] nzq[$];
    logic [7:0] bt;
    exp_t e;
    e.sm   = '0;
    e.data = '0;
    for (int k = 0; k < BUS; k++) begin
      bt = beat[8*k +: 8];
      if (bt != 8'h00) begin
        e.sm[k] = 1'b1;
        nzq.push_back(bt);
      end
    end
    e.nz = nzq.size();
    foreach (nzq[j]) e.data[8*j +: 8] = nzq[j];
    e.dat   = i % W;
    e.chunk = (b + i / W) % CN;
    e.last  = (i == l * W - 1);
    return e;
  endfunction

  function automatic logic [BUS*8-1:0] rand_beat();
    logic [BUS*8-1:0] d;
    int dens;
    dens = $urandom_range(0, 4);
    for (int k = 0; k < BUS; k++)
      d[8*k +: 8] = ($urandom_range(0, 3) < dens) ? 8'($urandom_range(1, 255)) : 8'h00;
    return d;
  endfunction

  // Monitor: pops one expectation per write strobe; checks hold when idle.
  initial begin
    logic [BUS-1:0]   psm;
    logic [BUS*8-1:0] pdata;
    exp_t e;
    psm   = '0;
    pdata = '0;
    forever begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (done) done_seen++;
      if (bus.wr_valid) begin
        if (q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_write: got chunk %0d dat %0d, expected no write",
                   bus.wr_chunk_count, bus.wr_dat_count);
        end else begin
          e = q.pop_front();
          check("sparsemap", bus.wr_sparsemap, e.sm);
          check("nonzero_data", bus.wr_nonzero_data, e.data);
          check("nz_count", bus.wr_nz_count, e.nz);
          check("dat_count", bus.wr_dat_count, e.dat);
          check("chunk_count", bus.wr_chunk_count, e.chunk);
          check("done_with_last", done, e.last);
        end
        psm   = bus.wr_sparsemap;
        pdata = bus.wr_nonzero_data;
      end else begin
        check("hold_map", bus.wr_sparsemap, psm);
        check("hold_data", bus.wr_nonzero_data, pdata);
      end
      if (rst) begin
        psm   = '0;
        pdata = '0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_check(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_ready"}, bus.dense_ready, 0);
    check({tag, "_wr_valid"}, bus.wr_valid, 0);
    check({tag, "_map"}, bus.wr_sparsemap, 0);
    check({tag, "_data"}, bus.wr_nonzero_data, 0);
    check({tag, "_nz"}, bus.wr_nz_count, 0);
    check({tag, "_dat"}, bus.wr_dat_count, 0);
    check({tag, "_chunk"}, bus.wr_chunk_count, 0);
  endtask

  task automatic start_xfer(input int b, input int l);
    base     = CW'(b);
    len      = LW'(l);
    start    = 1'b1;
    cur_base = b;
    cur_len  = l;
    cur_i    = 0;
    tick();
    start = 1'b0;
    if (l == 0) begin
      done_exp++;
      check("len0_done", done, 1);
      check("len0_busy", busy, 1);
      tick();
      check("len0_done_gone", done, 0);
      check("len0_idle", busy, 0);
    end
  endtask

  task automatic send_beat(input logic [BUS*8-1:0] d, input int gap, input bit poke);
    exp_t e;
    bit accepted, rdy;
    repeat (gap) tick();
    e = model(d, cur_i, cur_base, cur_len);
    q.push_back(e);
    bus.dense_dat   = d;
    bus.dense_valid = 1'b1;
    if (poke) begin
      start = 1'b1;
      len   = LW'(7);
    end
    accepted = 1'b0;
    for (int c = 0; c < 50 && !accepted; c++) begin
      rdy = bus.dense_ready;
      tick();
      accepted = rdy;
    end
    start           = 1'b0;
    bus.dense_valid = 1'b0;
    bus.dense_dat   = rand_beat();
    if (!accepted) begin
      vectors++;
      errors++;
      $display("FAIL accept_timeout: got no ready in 50 cycles, expected accept of beat %0d", cur_i);
    end
    if (e.last) done_exp++;
    cur_i++;
  endtask

  // mode: 0 random, 1 bytes 0/31 pattern, 2 zero beat then 0xFF beat.
  // gapmode: 0 continuous, 1 one idle cycle between beats, 2 random gaps.
  task automatic run_xfer(input int b, input int l, input int mode, input int gapmode, input bit poke);
    logic [BUS*8-1:0] d;
    int gap;
    start_xfer(b, l);
    for (int i = 0; i < l * W; i++) begin
      d = rand_beat();
      if (mode == 1) begin
        d = '0;
        d[7:0]             = 8'h11;
        d[BUS*8-1 -: 8]    = 8'h22;
      end else if (mode == 2 && i == 0) begin
        d = '0;
      end else if (mode == 2 && i == 1) begin
        d = '1;
      end
      gap = (gapmode == 0) ? 0 : (gapmode == 1) ? ((i == 0) ? 0 : 1) : $urandom_range(0, 3);
      send_beat(d, gap, poke && (i == 2));
    end
    if (l != 0) begin
      tick();
      check("idle_after_xfer", busy, 0);
    end
  endtask

  initial begin
    int b0;
    bus.dense_valid = 1'b0;
    bus.dense_dat   = '0;
    repeat (3) tick();
    reset_check("reset");
    rst = 1'b0;
    tick();
    reset_check("post_reset");

    run_xfer(0, 1, 1, 0, 1'b0);
    b0 = busy_cycles;
    run_xfer(14, 3, 0, 0, 1'b0);
    check("busy_cycles_len3", busy_cycles - b0, 13);
    run_xfer(3, 1, 0, 1, 1'b0);
    run_xfer(9, 1, 2, 0, 1'b0);
    run_xfer(6, 0, 0, 0, 1'b0);

    // Beats offered while idle must be ignored.
    bus.dense_dat   = rand_beat();
    bus.dense_valid = 1'b1;
    repeat (3) begin
      tick();
      check("idle_ready", bus.dense_ready, 0);
    end
    bus.dense_valid = 1'b0;
    tick();

    run_xfer(2, 2, 0, 0, 1'b1);

    // Abort after two beats of a two-chunk transfer.
    start_xfer(5, 2);
    send_beat(rand_beat(), 0, 1'b0);
    send_beat(rand_beat(), 0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    reset_check("abort");
    tick();
    check("abort_no_done", done, 0);
    run_xfer(11, 1, 0, 0, 1'b0);

    for (int t = 0; t < 10; t++)
      run_xfer($urandom_range(0, CN - 1), $urandom_range(0, 20), 0, 2, 1'b0);

    repeat (4) tick();
    check("queue_empty", q.size(), 0);
    check("done_count", done_seen, done_exp);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no end of test, expected finish within 2 ms");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
